// File: rtl/ecc_pkg.sv
// Shared field-arithmetic definitions for the ECC datapath: operand width,
// curve moduli and the multiplier sequencing states.
package ecc_pkg;

   localparam int unsigned WIDTH = 256;
   localparam int unsigned CNT_W = $clog2(WIDTH);

   localparam logic [WIDTH-1:0] P256 =
      256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
   localparam logic [WIDTH-1:0] P25519 =
      256'h7fffffffffffffffffffffffffffffffffffffffffffffffffffffffffffffed;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mul_mod_step.sv
// One radix-2 interleaved iteration: double-and-reduce, then conditionally add
// the multiplicand and reduce again. Purely combinational.
module mul_mod_step #(
   parameter int unsigned WIDTH = 256
) (
   input  logic [WIDTH-1:0] p,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] m,
   input  logic             b,
   output logic [WIDTH-1:0] p_next
);

   logic [WIDTH:0] dbl;
   logic [WIDTH:0] dbl_red;
   logic [WIDTH:0] sum;
   logic [WIDTH:0] sum_red;
   logic [WIDTH:0] m_ext;

   always_comb begin
      m_ext   = {1'b0, m};
      dbl     = {p, 1'b0};
      dbl_red = (dbl >= m_ext) ? dbl - m_ext : dbl;
      sum     = {1'b0, dbl_red[WIDTH-1:0]} + (b ? {1'b0, a} : '0);
      sum_red = (sum >= m_ext) ? sum - m_ext : sum;
      p_next  = sum_red[WIDTH-1:0];
   end

endmodule

// File: rtl/mul_mod.sv
// Iterative MSB-first modular multiplier: out_data = (opA * opB) mod opM,
// one multiplier bit per cycle under a start/busy/done handshake.
module mul_mod
   import ecc_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [WIDTH-1:0] opM,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out_data
);

   state_t           state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] m_r;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] p_nxt;
   logic [CNT_W-1:0] i_r;
   logic             last;

   mul_mod_step #(.WIDTH(WIDTH)) u_step (
      .p      (p_r),
      .a      (a_r),
      .m      (m_r),
      .b      (b_r[i_r]),
      .p_next (p_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         out_data <= '0;
         p_r      <= '0;
         i_r      <= '0;
         last     <= 1'b0;
         a_r      <= '0;
         b_r      <= '0;
         m_r      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_r   <= opA;
                  b_r   <= opB;
                  m_r   <= opM;
                  p_r   <= '0;
                  i_r   <= CNT_W'(WIDTH - 1);
                  last  <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               // After the i==0 iteration one more RUN cycle elapses before the
               // result is published, giving WIDTH+1 cycles from start to done.
               if (last) begin
                  out_data <= p_r;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  last     <= 1'b0;
                  state    <= DONE;
               end else begin
                  p_r <= p_nxt;
                  if (i_r == '0) last <= 1'b1;
                  else           i_r  <= i_r - 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_mod.sv
// Bench for mul_mod: table vectors, handshake/timing sequences and a random
// P256 back-to-back run, checked through an expected-result queue.
module tb_mul_mod;
   import ecc_pkg::*;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic [WIDTH-1:0] opM;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out_data;

   mul_mod dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .opA      (opA),
      .opB      (opB),
      .opM      (opM),
      .busy     (busy),
      .done     (done),
      .out_data (out_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] exp;
      int unsigned      cyc;
   } sb_t;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] m;
      logic [WIDTH-1:0] exp;
   } vec_t;

   sb_t         sb[$];
   int unsigned cyc   = 0;
   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic chk(input string n, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", n, act, exp, cyc);
      end
   endtask

   function automatic logic [WIDTH-1:0] ref_mulmod(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] m);
      logic [2*WIDTH-1:0] prod;
      prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
      return WIDTH'(prod % (2*WIDTH)'(m));
   endfunction

   function automatic logic [WIDTH-1:0] rnd256();
      logic [WIDTH-1:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r = {r[WIDTH-33:0], 32'($urandom)};
      return r;
   endfunction

   // Result monitor: every done pulse must match the oldest expected entry.
   always @(posedge clk) begin
      sb_t e;
      cyc = cyc + 1;
      #1;
      if (!rst && done) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got done=1 want done=0 (cycle %0d)", cyc);
         end else begin
            e = sb.pop_front();
            chk("result", out_data, e.exp);
            chk("done_cycle", WIDTH'(cyc), WIDTH'(e.cyc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Called 2 time units after an edge; start is sampled at the next edge.
   task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] exp);
      sb_t e;
      start = 1'b1;
      opA   = a;
      opB   = b;
      opM   = m;
      e.exp = exp;
      e.cyc = cyc + 1 + WIDTH + 1;
      sb.push_back(e);
      step();
      start = 1'b0;
      opA   = rnd256();
      opB   = rnd256();
      opM   = rnd256();
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         step();
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         total++;
         bad++;
         $display("FAIL done_timeout: got no done want done within 400 cycles (cycle %0d)", cyc);
      end
   endtask

   initial begin
      vec_t             vec[6];
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] exp1;

      x      = rnd256() % P256;
      vec[0] = '{a: 256'd3,      b: 256'd5,           m: 256'd7,  exp: 256'd1};
      vec[1] = '{a: P256 - 1,    b: P256 - 1,         m: P256,    exp: 256'd1};
      vec[2] = '{a: 256'd0,      b: x,                m: P256,    exp: 256'd0};
      vec[3] = '{a: 256'd2,      b: 256'd1 << 254,    m: P25519,  exp: 256'h13};
      vec[4] = '{a: 256'd10,     b: 256'd10,          m: 256'd13, exp: 256'd9};
      vec[5] = '{a: x,           b: 256'd1,           m: P256,    exp: x};

      rst   = 1'b1;
      start = 1'b0;
      opA   = '0;
      opB   = '0;
      opM   = '0;
      repeat (3) step();
      chk("reset_busy", WIDTH'(busy), '0);
      chk("reset_done", WIDTH'(done), '0);
      chk("reset_out", out_data, '0);
      rst = 1'b0;
      step();

      // Handshake timing of a single operation.
      issue(256'd3, 256'd5, 256'd7, 256'd1);
      chk("busy_after_start", WIDTH'(busy), WIDTH'(1));
      repeat (WIDTH) step();
      chk("busy_last_run", WIDTH'(busy), WIDTH'(1));
      chk("done_early", WIDTH'(done), '0);
      step();
      chk("done_pulse", WIDTH'(done), WIDTH'(1));
      chk("busy_in_done", WIDTH'(busy), '0);
      step();
      chk("done_one_cycle", WIDTH'(done), '0);
      chk("out_held_idle", out_data, 256'd1);

      for (int v = 0; v < 6; v++) begin
         issue(vec[v].a, vec[v].b, vec[v].m, vec[v].exp);
         wait_done();
         step();
      end

      // start during RUN is ignored.
      issue(256'd6, 256'd6, 256'd7, 256'd1);
      repeat (99) step();
      start = 1'b1;
      opA   = 256'd4;
      opB   = 256'd5;
      opM   = 256'd11;
      step();
      start = 1'b0;
      wait_done();
      repeat (5) step();

      // Reset mid-RUN abandons the operation.
      issue(P256 - 2, P256 - 3, P256, ref_mulmod(P256 - 2, P256 - 3, P256));
      repeat (119) step();
      rst = 1'b1;
      step();
      sb.delete();
      chk("midrst_busy", WIDTH'(busy), '0);
      chk("midrst_done", WIDTH'(done), '0);
      chk("midrst_out", out_data, '0);
      rst = 1'b0;
      step();
      issue(P256 - 2, P256 - 3, P256, ref_mulmod(P256 - 2, P256 - 3, P256));
      wait_done();
      step();

      // Back-to-back: start in the DONE cycle, earlier result held meanwhile.
      exp1 = ref_mulmod(256'd12345, P256 - 5, P256);
      issue(256'd12345, P256 - 5, P256, exp1);
      wait_done();
      issue(256'd777, 256'd999, P256, 256'd776223);
      repeat (WIDTH) step();
      chk("b2b_out_held", out_data, exp1);
      chk("b2b_no_early_done", WIDTH'(done), '0);
      wait_done();

      // Random P256 vectors, chained back-to-back.
      a = rnd256() % P256;
      b = rnd256() % P256;
      issue(a, b, P256, ref_mulmod(a, b, P256));
      for (int k = 0; k < 200; k++) begin
         wait_done();
         if (k < 199) begin
            a = rnd256() % P256;
            b = rnd256() % P256;
            issue(a, b, P256, ref_mulmod(a, b, P256));
         end
      end
      repeat (3) step();
      chk("sb_drained", WIDTH'(sb.size()), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_mod.md
# mul_mod

Iterative radix-2 interleaved modular multiplier that computes out_data = (opA · opB) mod opM for 256-bit ECC field operands. It sits in the field-arithmetic datapath beside the modular subtractor and consumes its reduced outputs as multiplicands. Its results feed point-add/double sequencing and back into the subtractor. It processes one multiplier bit per cycle, MSB first, under a start/busy/done handshake.

## Interface
- WIDTH, 256, operand and modulus width in bits.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only while busy==0.
- opA  input  WIDTH  multiplicand; precondition opA < opM.
- opB  input  WIDTH  multiplier; precondition opB < opM.
- opM  input  WIDTH  modulus; precondition opM != 0.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when out_data becomes valid.
- out_data  output  WIDTH  result; held stable from done until the next accepted start.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1, bit counter i runs WIDTH-1 down to 0.
  - DONE: busy=0, done=1.
- IDLE or DONE with start=1:
  - Latch opA, opB, opM into internal registers.
  - Clear accumulator P.
  - Set i=WIDTH-1 and go to RUN.
  - Inputs are don't-care after this capture.
- RUN, one iteration per cycle:
  - P1 = 2P; if P1 ≥ M then P1 −= M.
  - P2 = P1 + (B[i] ? A : 0); if P2 ≥ M then P2 −= M.
  - P = P2.
  - If i==0, go to DONE; otherwise i −= 1.
- DONE lasts exactly one cycle:
  - out_data ← P, registered on entry to DONE.
  - Next state is IDLE, or RUN if start=1 in that cycle.
- start during RUN is ignored, with no queueing.
- Width rule: P is WIDTH bits; intermediate sums are WIDTH+1 bits. Each step stays < M given the preconditions.
- Precondition violation (opA ≥ opM, opB ≥ opM, or opM==0):
  - out_data is undefined.
  - Latency and handshake are unchanged; the block must never hang.
- Reset: from any state, including mid-RUN, the next state is IDLE with busy=0, done=0, out_data=0, P=0, i=0. No partial result is retained.

## Timing
- Reset values: busy=0, done=0, out_data=0.
- start sampled high at edge 0:
  - busy=1 after edge 0.
  - WIDTH iterations at edges 1..WIDTH.
  - done=1 and out_data valid after edge WIDTH+1.
  - Latency = WIDTH+1 cycles from start to done (257 at default).
- Back-to-back: start in the DONE cycle begins the next operation. Throughput is one result per WIDTH+1 cycles.
- Critical path: one doubling with compare-subtract, then one add with compare-subtract, in a single cycle. No multi-cycle paths.

## Structure
- Shared package ecc_pkg:
  - WIDTH constant (256).
  - Moduli constants P256 and P25519.
  - State enum {IDLE, RUN, DONE}.
- Sub-module mul_mod_step:
  - Purely combinational single iteration.
  - Inputs: P, A, M, bit b. Output: next P.
  - Instantiated once.
- Top holds the FSM, the counter and the operand/result registers.

## Test plan
- opA=3, opB=5, opM=7, start at cycle 0 → done pulses once at cycle 257, out_data=1, busy high over cycles 1–256.
- opM=P256, opA=opB=P256−1 → out_data=1. opA=0 with any opB → out_data=0.
- opM=2^255−19, opA=2, opB=2^254 → out_data=19 (0x13).
- start re-asserted at cycle 100 with different operands → ignored. Result matches the first operands; done still at cycle 257.
- rst asserted at cycle 120 of RUN → next cycle busy=0, done=0, out_data=0. A fresh start then completes with the correct result.
- Back-to-back: start in the DONE cycle with new operands → second done exactly 257 cycles later. The first out_data stays held until that point; 200 random P256 vectors checked against a reference model.
